wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter. Shares the single BlockRAM slave port between two requesters, e.g. master 0 = video frame reader, master 1 = pattern/CPU writer.
- Grants on cyc, holds the grant for the whole cycle (classic or burst), and re-arbitrates round-robin.
- Slave-side signals are a registered-grant multiplexer. ack/dat_sm are routed back to the granted master only.

Parameters:
- ADR_W, 32, address width on both master and slave sides.
- DAT_W, 32, data width; sel width is DAT_W/8.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mX_cyc  input  1  master X (X=0,1) bus-cycle request.
- mX_stb  input  1  master X strobe.
- mX_we  input  1  master X write enable.
- mX_adr  input  ADR_W  master X byte address.
- mX_dat_ms  input  DAT_W  master X write data.
- mX_sel  input  DAT_W/8  master X byte selects.
- mX_cti  input  3  master X cycle type (000 classic, 010 incrementing burst, 111 end of burst).
- mX_bte  input  2  master X burst type.
- mX_dat_sm  output  DAT_W  read data to master X.
- mX_ack  output  1  acknowledge to master X.
- s_cyc, s_stb, s_we  output  1 each  to slave.
- s_adr  output  ADR_W  to slave.
- s_dat_ms  output  DAT_W  to slave.
- s_sel  output  DAT_W/8  to slave.
- s_cti  output  3  to slave.
- s_bte  output  2  to slave.
- s_dat_sm  input  DAT_W  from slave.
- s_ack  input  1  from slave.
- grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registered; grant decodes from state.
- Reset (rst=1 at clk edge): state IDLE, last_owner=1, grant=00. Reset mid-transfer aborts immediately; slave sees s_cyc=s_stb=0 from the next cycle.
- IDLE transitions:
  - only m0_cyc → OWN0; only m1_cyc → OWN1.
  - both → the master that is not last_owner.
  - neither → stay IDLE.
- OWNx: stay while mx_cyc=1. The grant is never preempted, including during bursts.
- OWNx with mx_cyc=0: last_owner<=x.
  - If the other master's cyc=1, go directly to OWN(other). No idle cycle; the other master's first strobe reaches the slave one cycle after release.
  - Else go to IDLE.
- Grant latency: a request seen in IDLE at edge N drives s_cyc from edge N onward (one-cycle arbitration latency).
- Slave mux (combinational from state):
  - OWNx: all s_* outputs equal the corresponding mX_* inputs.
  - IDLE: s_cyc=s_stb=s_we=0, s_cti=000, s_bte=00, s_adr/s_dat_ms/s_sel=0.
- Return path: mx_ack = s_ack when state=OWNx, else 0. mx_dat_sm = s_dat_sm always; masters qualify it with ack. The non-granted master's ack is always 0.
- Non-granted master waits with cyc/stb asserted, and must see no ack. Its stb is never forwarded.
- Grant changes happen only on clk edges. No combinational path from m*_cyc to grant.
- Masters dropping cyc with stb still high are treated as cycle end; the stb is ignored.
- Fairness: under continuous requests from both masters, ownership alternates 0,1,0,1… per cycle (per cyc deassertion).

Test Plan:
1. rst=1 for 3 cycles with m0_cyc=m0_stb=1 → grant=00, s_cyc=0, m0_ack=0. Release rst, so edge N sees IDLE with m0_cyc=1 → grant=01 after edge N; s_adr follows m0_adr.
2. Classic read by m0 at adr 0x10 while m1 idle; slave acks one cycle later with 0xCAFEF00D → m0_ack=1, m0_dat_sm=0xCAFEF00D, m1_ack=0 throughout. After m0_cyc falls, grant=00 next cycle.
3. Both cyc rise in the same cycle after reset → m0 granted first (last_owner reset=1). m0 completes a 1-word write of 0xA5A5A5A5 at 0x20 and drops cyc → grant=10 next cycle with no IDLE gap; m1 read of 0x20 returns 0xA5A5A5A5.
4. m1 runs a 4-beat burst (cti 010,010,010,111) while m0 requests from beat 1 → grant stays 10 for all 4 acks; m0_ack=0. Grant=01 the cycle after m1_cyc drops.
5. Both masters re-request continuously (each drops cyc for one cycle after its ack) for 8 cycles → grant sequence alternates 01,10,01,10. No master is granted twice in a row while the other is waiting.
6. rst asserted during m0 burst beat 2 → next cycle s_cyc=s_stb=0, m0_ack=0, grant=00. After release with only m1_cyc=1 → grant=10.

Source files
------------

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2 : two-master / one-slave Wishbone arbiter.
//
// Shares one Wishbone slave port (e.g. a BlockRAM) between two masters. A
// master is granted when its cyc rises. It keeps the grant until it drops
// cyc, so classic cycles and bursts are never preempted. Contention is then
// settled round-robin against the last owner.
//
// Handshake: a master owns the slave while its grant bit is set. Its stb,
// adr, we, dat_ms, sel, cti and bte are forwarded unchanged. s_ack is
// returned only to the owner. A waiting master may hold cyc/stb high for any
// length of time. It sees no ack and none of its signals reach the slave.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   mX_cyc/stb/we/adr/dat_ms/sel/cti/bte (X=0,1) : master request side
//   mX_dat_sm, mX_ack   : return path to master X
//   s_*                 : slave side, multiplexed from the owning master
//   s_dat_sm, s_ack     : slave response
//   grant               : one-hot owner (bit0 = m0, bit1 = m1), 00 when idle;
//                         this is a direct decode of the arbitration state
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
   parameter int ADR_W = 32,
   parameter int DAT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               m0_cyc,
   input  logic               m0_stb,
   input  logic               m0_we,
   input  logic [ADR_W-1:0]   m0_adr,
   input  logic [DAT_W-1:0]   m0_dat_ms,
   input  logic [DAT_W/8-1:0] m0_sel,
   input  logic [2:0]         m0_cti,
   input  logic [1:0]         m0_bte,
   output logic [DAT_W-1:0]   m0_dat_sm,
   output logic               m0_ack,
   input  logic               m1_cyc,
   input  logic               m1_stb,
   input  logic               m1_we,
   input  logic [ADR_W-1:0]   m1_adr,
   input  logic [DAT_W-1:0]   m1_dat_ms,
   input  logic [DAT_W/8-1:0] m1_sel,
   input  logic [2:0]         m1_cti,
   input  logic [1:0]         m1_bte,
   output logic [DAT_W-1:0]   m1_dat_sm,
   output logic               m1_ack,
   output logic               s_cyc,
   output logic               s_stb,
   output logic               s_we,
   output logic [ADR_W-1:0]   s_adr,
   output logic [DAT_W-1:0]   s_dat_ms,
   output logic [DAT_W/8-1:0] s_sel,
   output logic [2:0]         s_cti,
   output logic [1:0]         s_bte,
   input  logic [DAT_W-1:0]   s_dat_sm,
   input  logic               s_ack,
   output logic [1:0]         grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;
   logic   r_last_owner;
   logic   w_next_last_owner;

   // State register. Reset leaves last_owner at 1 so that m0 wins the first
   // simultaneous request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
      end else begin
         r_state      <= w_next_state;
         r_last_owner <= w_next_last_owner;
      end
   end

   // Next-state logic. A release hands the slave straight to a waiting
   // master, so there is no idle cycle between back-to-back owners.
   always_comb begin
      w_next_state      = r_state;
      w_next_last_owner = r_last_owner;
      case (r_state)
         IDLE: begin
            if (m0_cyc && m1_cyc) begin
               w_next_state = r_last_owner ? OWN0 : OWN1;
            end else if (m0_cyc) begin
               w_next_state = OWN0;
            end else if (m1_cyc) begin
               w_next_state = OWN1;
            end
         end
         OWN0: begin
            if (!m0_cyc) begin
               w_next_last_owner = 1'b0;
               w_next_state      = m1_cyc ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!m1_cyc) begin
               w_next_last_owner = 1'b1;
               w_next_state      = m0_cyc ? OWN0 : IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Grant is decoded from the registered state only. It has no combinational
   // path from any cyc input.
   assign grant = {(r_state == OWN1), (r_state == OWN0)};

   // Slave-side multiplexer. Every output is driven to zero when idle, so the
   // slave never sees stale address or data.
   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_ms = '0;
      s_sel    = '0;
      s_cti    = 3'b000;
      s_bte    = 2'b00;
      case (r_state)
         OWN0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
            s_cti    = m0_cti;
            s_bte    = m0_bte;
         end
         OWN1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
            s_cti    = m1_cti;
            s_bte    = m1_bte;
         end
         default: ;
      endcase
   end

   // Read data is broadcast to both masters, and each master qualifies it
   // with its own ack. Only ack is steered by ownership.
   assign m0_dat_sm = s_dat_sm;
   assign m1_dat_sm = s_dat_sm;
   assign m0_ack    = (r_state == OWN0) && s_ack;
   assign m1_ack    = (r_state == OWN1) && s_ack;

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2 : self-checking bench for wb_arbiter2.
//
// Contains a behavioural BlockRAM slave that acks one cycle after a strobe.
// Two master driver tasks can run concurrently. A grant-history monitor
// records every change of grant. Read expectations come from a reference
// memory. They are queued when a read is issued and popped on the master's
// ack.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

   localparam int ADR_W = 32;
   localparam int DAT_W = 32;

   logic              clk;
   logic              rst;
   logic              m0_cyc, m0_stb, m0_we;
   logic [ADR_W-1:0]  m0_adr;
   logic [DAT_W-1:0]  m0_dat_ms;
   logic [3:0]        m0_sel;
   logic [2:0]        m0_cti;
   logic [1:0]        m0_bte;
   logic [DAT_W-1:0]  m0_dat_sm;
   logic              m0_ack;
   logic              m1_cyc, m1_stb, m1_we;
   logic [ADR_W-1:0]  m1_adr;
   logic [DAT_W-1:0]  m1_dat_ms;
   logic [3:0]        m1_sel;
   logic [2:0]        m1_cti;
   logic [1:0]        m1_bte;
   logic [DAT_W-1:0]  m1_dat_sm;
   logic              m1_ack;
   logic              s_cyc, s_stb, s_we;
   logic [ADR_W-1:0]  s_adr;
   logic [DAT_W-1:0]  s_dat_ms;
   logic [3:0]        s_sel;
   logic [2:0]        s_cti;
   logic [1:0]        s_bte;
   logic [DAT_W-1:0]  s_dat_sm;
   logic              s_ack;
   logic [1:0]        grant;

   wb_arbiter2 #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
      .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
      .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_dat_sm(s_dat_sm), .s_ack(s_ack),
      .grant(grant)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard / reference memory ----------------
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [31:0] model_mem [64];
   logic [31:0] slv_mem   [64];
   logic [1:0]  glog[$];
   logic [1:0]  g_prev = 2'b00;

   // ---------------- behavioural slave ----------------
   // Acks one cycle after it first sees a strobe. The !s_ack term gives
   // one ack per strobe for classic cycles and one every other cycle in
   // bursts.
   always @(posedge clk) begin
      if (rst) begin
         s_ack <= 1'b0;
      end else begin
         s_ack <= s_cyc && s_stb && !s_ack;
         if (s_cyc && s_stb && !s_ack) begin
            if (s_we) slv_mem[s_adr[7:2]] <= s_dat_ms;
            s_dat_sm <= slv_mem[s_adr[7:2]];
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      check_eq("ack_exclusive", {31'd0, m0_ack & m1_ack}, 32'd0);
      check_eq("grant_legal", {31'd0, grant == 2'b11}, 32'd0);
      if (grant !== g_prev) begin
         glog.push_back(grant);
         g_prev = grant;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
      if (m == 0) begin
         m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr;
         m0_dat_ms = dat; m0_sel = 4'hF; m0_cti = cti; m0_bte = 2'b00;
      end else begin
         m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr;
         m1_dat_ms = dat; m1_sel = 4'hF; m1_cti = cti; m1_bte = 2'b00;
      end
   endtask

   task automatic wait_ack(input int m, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq(m == 0 ? "m0_ack_timeout" : "m1_ack_timeout", 32'd0, 32'd1);
   endtask

   // One classic cycle (beats==1) or an incrementing burst.
   task automatic m_xfer(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input int beats);
      bit          ok;
      logic [2:0]  cti;
      logic [31:0] a;
      logic [31:0] exp_v;
      logic [31:0] obs_v;
      for (int b = 0; b < beats; b++) begin
         a   = adr + 32'(4 * b);
         cti = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
         set_m(m, 1'b1, 1'b1, we, a, dat + 32'(b), cti);
         if (we) model_mem[a[7:2]] = dat + 32'(b);
         else if (m == 0) exp_q0.push_back(model_mem[a[7:2]]);
         else exp_q1.push_back(model_mem[a[7:2]]);
         wait_ack(m, ok);
         if (!ok) break;
         check_eq("other_ack", {31'd0, (m == 0) ? m1_ack : m0_ack}, 32'd0);
         if (!we) begin
            obs_v = (m == 0) ? m0_dat_sm : m1_dat_sm;
            if (m == 0) exp_v = exp_q0.pop_front();
            else exp_v = exp_q1.pop_front();
            check_eq(m == 0 ? "m0_rdata" : "m1_rdata", obs_v, exp_v);
         end
         tick();
      end
      set_m(m, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Compare the recorded grant history with n packed 2-bit entries (oldest first).
   task automatic check_glog(input string tag, input int n, input logic [15:0] exp_p);
      check_eq({tag, "_len"}, 32'(glog.size()), 32'(n));
      for (int i = 0; i < n && i < glog.size(); i++)
         check_eq(tag, {30'd0, glog[i]}, {30'd0, exp_p[2*(n-1-i) +: 2]});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = 32'h5A00_0000 | 32'(i * 17);
         slv_mem[i]   = 32'h5A00_0000 | 32'(i * 17);
      end
      model_mem[4] = 32'hCAFE_F00D;
      slv_mem[4]   = 32'hCAFE_F00D;
      set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);

      // 1: reset with m0 requesting, then one-cycle grant latency
      rst = 1'b1;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 3'b000);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("rst_grant", {30'd0, grant}, 32'd0);
         check_eq("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
         check_eq("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("t1_grant", {30'd0, grant}, 32'h1);
      check_eq("t1_s_cyc", {31'd0, s_cyc}, 32'd1);
      check_eq("t1_s_adr", s_adr, 32'h40);
      set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      repeat (2) tick();

      // 2: classic read by m0, m1 idle
      m_xfer(0, 1'b0, 32'h10, 32'd0, 1);
      @(posedge clk);
      @(negedge clk);
      check_eq("t2_grant_idle", {30'd0, grant}, 32'd0);

      // 3: simultaneous request after reset -> m0 first, direct hand-off to m1
      do_reset();
      tick();
      glog.delete();
      model_mem[8] = 32'hA5A5_A5A5;
      fork
         m_xfer(0, 1'b1, 32'h20, 32'hA5A5_A5A5, 1);
         m_xfer(1, 1'b0, 32'h20, 32'd0, 1);
      join
      repeat (3) tick();
      check_glog("t3_glog", 3, {10'd0, 2'b01, 2'b10, 2'b00});

      // 4: m1 4-beat burst is not preempted by m0
      glog.delete();
      fork
         m_xfer(1, 1'b0, 32'h30, 32'd0, 4);
         begin
            repeat (3) tick();
            m_xfer(0, 1'b1, 32'h44, 32'h1111_2222, 1);
         end
      join
      repeat (3) tick();
      check_glog("t4_glog", 3, {10'd0, 2'b10, 2'b01, 2'b00});

      // 5: continuous requests alternate ownership
      do_reset();
      tick();
      glog.delete();
      fork
         repeat (2) begin
            m_xfer(0, 1'b0, 32'h80, 32'd0, 1);
            tick();
         end
         repeat (2) begin
            m_xfer(1, 1'b0, 32'h84, 32'd0, 1);
            tick();
         end
      join
      repeat (3) tick();
      check_glog("t5_glog", 5, {6'd0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00});

      // 6: reset during beat 2 of an m0 burst aborts immediately
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'd0, 3'b010);
      wait_ack(0, ok);
      tick();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h54, 32'd0, 3'b010);
      wait_ack(0, ok);
      tick();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h58, 32'd0, 3'b010);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("t6_s_cyc", {31'd0, s_cyc}, 32'd0);
      check_eq("t6_s_stb", {31'd0, s_stb}, 32'd0);
      check_eq("t6_m0_ack", {31'd0, m0_ack}, 32'd0);
      check_eq("t6_grant", {30'd0, grant}, 32'd0);
      rst = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      fork
         m_xfer(1, 1'b0, 32'h60, 32'd0, 1);
         begin
            @(negedge clk);
            check_eq("t6_grant_m1", {30'd0, grant}, 32'h2);
         end
      join
      repeat (3) tick();

      check_eq("exp_q0_empty", 32'(exp_q0.size()), 32'd0);
      check_eq("exp_q1_empty", 32'(exp_q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
